// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  localparam int ADDR_W      = 64;
  localparam int DATA_W      = 64;
  localparam int MEM_LAT_DEF = 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic {GNT_I, GNT_D} grant_t;
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin tie-break: on a tie, the requester not granted last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,        // [0]=fetch, [1]=data
  input  grant_t     last_grant,
  output grant_t     grant
);
  always_comb begin
    grant = GNT_I;
    if (req == 2'b11) grant = (last_grant == GNT_I) ? GNT_D : GNT_I;
    else if (req[1])  grant = GNT_D;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one registered memory
// interface; one transaction in flight, IDLE -> ISSUE -> (WAIT) -> RESP.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = MEM_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  grant_t     gnt, last_grant, pick;
  logic [2:0] cnt;
  logic       lat_wr;

  rr_pick2 u_pick (
    .req       ({d_req, i_req}),
    .last_grant(last_grant),
    .grant     (pick)
  );

  assign busy = (state != S_IDLE);

  // mem_addr/mem_wdata double as the address/data latches, so later
  // requester-side changes never reach memory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      gnt        <= GNT_I;
      last_grant <= GNT_D;
      cnt        <= '0;
      lat_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wr     <= 1'b0;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_req || d_req) begin
          gnt        <= pick;
          last_grant <= pick;
          state      <= S_ISSUE;
          if (pick == GNT_D) begin
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            lat_wr    <= d_wr;
            mem_wr    <= d_wr;
          end else begin
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            lat_wr    <= 1'b0;
            mem_wr    <= 1'b0;
          end
        end
        S_ISSUE: begin
          mem_wr <= 1'b0;
          if (lat_wr) begin
            state <= S_RESP;
            i_ack <= (gnt == GNT_I);
            d_ack <= (gnt == GNT_D);
          end else begin
            state <= S_WAIT;
            cnt   <= LAT_M1;
          end
        end
        S_WAIT: begin
          if (cnt == 3'd0) begin
            if (gnt == GNT_I) i_rdata <= mem_rdata[31:0];
            else              d_rdata <= mem_rdata;
            i_ack <= (gnt == GNT_I);
            d_ack <= (gnt == GNT_D);
            state <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        S_RESP: begin
          i_ack <= 1'b0;
          d_ack <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 1, meaning memory read latency in cycles (legal range 1..7).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  the single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 i_req  in  1  instruction-fetch request, read-only.
REQ-006 i_addr  in  64  fetch byte address.
REQ-007 i_ack  out  1  one-cycle fetch completion pulse.
REQ-008 i_rdata  out  32  fetched word, valid only while i_ack=1.
REQ-009 d_req  in  1  data request.
REQ-010 d_wr  in  1  1=store, 0=load; sampled with d_req.
REQ-011 d_addr  in  64  data byte address.
REQ-012 d_wdata  in  64  store data.
REQ-013 d_ack  out  1  one-cycle data completion pulse.
REQ-014 d_rdata  out  64  load data, valid only while d_ack=1.
REQ-015 mem_addr  out  64  shared memory address, registered.
REQ-016 mem_wdata  out  64  shared memory write data, registered.
REQ-017 mem_wr  out  1  shared memory write strobe, registered.
REQ-018 mem_rdata  in  64  shared memory read data.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 The block SHALL implement states IDLE, ISSUE, WAIT and RESP.
REQ-021 IDLE: on any request, the block SHALL grant one requester, latch its address, write data and direction, and go to ISSUE.
REQ-022 With exactly one request pending, that requester SHALL be granted.
REQ-023 With both requests pending, the requester not granted last SHALL win (2-way round robin); last_grant SHALL update on every grant.
REQ-024 ISSUE: mem_addr and mem_wdata SHALL be driven from the latched values; mem_wr SHALL be 1 only in ISSUE of a store.
REQ-025 From ISSUE, a store SHALL go to RESP and a load SHALL go to WAIT.
REQ-026 WAIT SHALL last MEM_LAT cycles (3-bit counter) with mem_addr held stable, then capture mem_rdata and go to RESP.
REQ-027 RESP SHALL pulse the granted requester's ack for exactly one cycle, then return to IDLE.
REQ-028 Fetch: i_rdata SHALL equal captured mem_rdata[31:0]; mem_rdata[63:32] SHALL be discarded.
REQ-029 Latency: with the request sampled in IDLE at edge N, a store ack SHALL occur at cycle N+2 and a load ack at cycle N+2+MEM_LAT.
REQ-030 Throughput: the block SHALL allow at most one transaction in flight; a requester may re-request in the cycle after its ack.
REQ-031 A requester SHALL hold req and payload until ack; if req drops mid-transaction, the transaction SHALL still complete and ack SHALL still pulse.
REQ-032 Changes to address or data after grant SHALL be ignored.
REQ-033 The ungranted requester SHALL wait with no ack and no lost request.
REQ-034 i_ack and d_ack SHALL never be high together.
REQ-035 i_rdata and d_rdata SHALL hold their last captured value and SHALL be 0 after reset.

Reset
REQ-036 While reset=0 the block SHALL force: state IDLE; all outputs, the counter and the latches 0; last_grant=D, so I wins the first tie.
REQ-037 Reset asserted mid-transaction SHALL abort the transaction with no ack and no mem_wr after release.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum, the grant enum {GNT_I, GNT_D}, the ADDR_W=64 and DATA_W=64 constants, and the MEM_LAT default.
REQ-039 The tie-break logic SHALL be one sub-module, rr_pick2 (inputs req[1:0] and last_grant; output grant), in combinational form.

Verification
REQ-040 MEM_LAT=1, single load d_req at edge 0, d_addr=0x40, memory returns 0x1122334455667788 -> d_ack at cycle 3 with that value, no mem_wr.
REQ-041 Single store d_addr=0x80, d_wdata=0xDEADBEEF -> mem_wr=1 in cycle 1 only with addr 0x80 and data 0xDEADBEEF; d_ack at cycle 2.
REQ-042 i_req and d_req both high from reset release -> grants alternate I,D,I,D; each ack matches its own address; the two acks never coincide.
REQ-043 Fetch i_addr=0x0, memory returns 0xAAAAAAAA00000013 -> i_rdata=0x00000013.
REQ-044 Reset pulsed during WAIT (MEM_LAT=3) -> no ack; outputs 0; the next request is serviced normally.
REQ-045 d_req dropped the cycle after grant -> d_ack still pulses once and the block returns to IDLE.
